// File: rtl/iram_controller.sv
// Instruction-RAM line refill controller: on a cache miss, fetches the whole line
// critical-word-first over a single-outstanding req/ack/rvalid port.
module iram_controller #(
    parameter int PC_SIZE    = 32,
    parameter int WORD_SIZE  = 32,
    parameter int LINE_WORDS = 4,
    localparam int OFF_W     = $clog2(LINE_WORDS)
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 miss_cache,
    input  logic [PC_SIZE-1:0]   ram_address,
    output logic [WORD_SIZE-1:0] mem_word,
    output logic                 word_ready,
    output logic [OFF_W-1:0]     word_offset,
    output logic                 refill_done,
    output logic                 iram_req,
    output logic [PC_SIZE-1:0]   iram_addr,
    input  logic                 iram_ack,
    input  logic                 iram_rvalid,
    input  logic [WORD_SIZE-1:0] iram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [PC_SIZE-1:0] LINE_MASK =
        ~((PC_SIZE'(1) << (OFF_W + 2)) - PC_SIZE'(1));

    state_t                 state_q, state_d;
    logic [PC_SIZE-1:0]     base_q, base_d;
    logic [OFF_W-1:0]       off_q, off_d;
    logic [OFF_W-1:0]       cnt_q, cnt_d;
    logic [WORD_SIZE-1:0]   mem_word_q, mem_word_d;
    logic [OFF_W-1:0]       word_offset_q, word_offset_d;
    logic                   word_ready_q, word_ready_d;
    logic                   refill_done_q, refill_done_d;

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q       <= ST_IDLE;
            base_q        <= '0;
            off_q         <= '0;
            cnt_q         <= '0;
            mem_word_q    <= '0;
            word_offset_q <= '0;
            word_ready_q  <= 1'b0;
            refill_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            off_q         <= off_d;
            cnt_q         <= cnt_d;
            mem_word_q    <= mem_word_d;
            word_offset_q <= word_offset_d;
            word_ready_q  <= word_ready_d;
            refill_done_q <= refill_done_d;
        end
    end

    // Next-state logic; offset wraps naturally because LINE_WORDS is a power of 2
    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        off_d         = off_q;
        cnt_d         = cnt_q;
        mem_word_d    = mem_word_q;
        word_offset_d = word_offset_q;
        word_ready_d  = 1'b0;
        refill_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (miss_cache) begin
                    base_d  = ram_address & LINE_MASK;
                    off_d   = ram_address[OFF_W+1:2];
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (iram_ack) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (iram_rvalid) begin
                    mem_word_d    = iram_rdata;
                    word_offset_d = off_q;
                    word_ready_d  = 1'b1;
                    off_d         = off_q + OFF_W'(1);
                    cnt_d         = cnt_q + OFF_W'(1);
                    if (cnt_q == OFF_W'(LINE_WORDS - 1)) begin
                        refill_done_d = 1'b1;
                        state_d       = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            // One dead cycle so the cache can mark the line valid before the next miss
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign iram_req    = (state_q == ST_REQ);
    assign iram_addr   = (state_q == ST_REQ)
                       ? (base_q | {{(PC_SIZE-OFF_W-2){1'b0}}, off_q, 2'b00})
                       : '0;
    assign mem_word    = mem_word_q;
    assign word_offset = word_offset_q;
    assign word_ready  = word_ready_q;
    assign refill_done = refill_done_q;

endmodule

// File: tb/tb_iram_controller.sv
// Scoreboard bench for iram_controller: expected words are queued when a miss is
// driven and compared against each word_ready pulse.
module tb_iram_controller;

    logic        clk = 1'b0;
    logic        nrst;
    logic        miss_cache;
    logic [31:0] ram_address;
    logic [31:0] mem_word;
    logic        word_ready;
    logic [1:0]  word_offset;
    logic        refill_done;
    logic        iram_req;
    logic [31:0] iram_addr;
    logic        iram_ack;
    logic        iram_rvalid;
    logic [31:0] iram_rdata;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  off;
        logic        done;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    iram_controller dut (
        .clk         (clk),
        .nrst        (nrst),
        .miss_cache  (miss_cache),
        .ram_address (ram_address),
        .mem_word    (mem_word),
        .word_ready  (word_ready),
        .word_offset (word_offset),
        .refill_done (refill_done),
        .iram_req    (iram_req),
        .iram_addr   (iram_addr),
        .iram_ack    (iram_ack),
        .iram_rvalid (iram_rvalid),
        .iram_rdata  (iram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] word_addr(input logic [31:0] a, input int i);
        logic [1:0] o;
        o = a[3:2] + 2'(i);
        return {a[31:4], o, 2'b00};
    endfunction

    // Scoreboard: compare each returned word against the queued expectation
    always @(negedge clk) begin
        if (word_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("mem_word", mem_word, e.data);
                chk("word_offset", {30'd0, word_offset}, {30'd0, e.off});
                chk("refill_done", {31'd0, refill_done}, {31'd0, e.done});
                if (e.cyc >= 0) chk("ready_cycle", cyc, e.cyc);
            end
        end else if (refill_done) begin
            chk("done_without_ready", 32'd1, 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue n expected words of the line for a miss accepted in cycle t0 (-1: no timing check)
    task automatic push_line(input logic [31:0] a, input int t0, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.data = word_addr(a, i) ^ 32'hA5A5_0000;
            e.off  = a[3:2] + 2'(i);
            e.done = (i == 3);
            e.cyc  = (t0 < 0) ? -1 : t0 + 3 + 2 * i;
            sb_q.push_back(e);
        end
    endtask

    // Act as the RAM for n words; word 'slow' gets ack delay aw and rvalid delay rw
    task automatic serve_line(input logic [31:0] a, input int n, input int slow,
                              input int aw, input int rw);
        for (int i = 0; i < n; i++) begin
            int g = 0;
            logic [31:0] lat;
            while (!iram_req && g < 20) begin
                step();
                g++;
            end
            chk("req_seen", {31'd0, iram_req}, 32'd1);
            for (int w = 0; w < ((i == slow) ? aw : 0); w++) begin
                iram_ack = 1'b0;
                chk("req_held", {31'd0, iram_req}, 32'd1);
                chk("addr_held", iram_addr, word_addr(a, i));
                step();
            end
            iram_ack = 1'b1;
            chk("iram_addr", iram_addr, word_addr(a, i));
            lat = iram_addr;
            step();
            iram_ack = 1'b0;
            for (int w = 0; w < ((i == slow) ? rw : 0); w++) begin
                chk("req_low_wait", {31'd0, iram_req}, 32'd0);
                step();
            end
            iram_rvalid = 1'b1;
            iram_rdata  = lat ^ 32'hA5A5_0000;
            step();
            iram_rvalid = 1'b0;
            iram_rdata  = 32'hDEAD_BEEF;
        end
    endtask

    // Full refill; mode 0: miss held until end, 1: miss dropped after acceptance
    task automatic refill(input logic [31:0] a, input int mode, input int slow,
                          input int aw, input int rw);
        step();
        miss_cache  = 1'b1;
        ram_address = a;
        push_line(a, (slow < 0) ? cyc : -1, 4);
        step();
        if (mode == 1) miss_cache = 1'b0;
        serve_line(a, 4, slow, aw, rw);
        miss_cache = 1'b0;
    endtask

    initial begin
        int t0;
        nrst        = 1'b0;
        miss_cache  = 1'b0;
        ram_address = 32'd0;
        iram_ack    = 1'b0;
        iram_rvalid = 1'b0;
        iram_rdata  = 32'd0;
        repeat (3) step();
        chk("rst_word_ready", {31'd0, word_ready}, 32'd0);
        chk("rst_refill_done", {31'd0, refill_done}, 32'd0);
        chk("rst_mem_word", mem_word, 32'd0);
        chk("rst_word_offset", {30'd0, word_offset}, 32'd0);
        chk("rst_iram_req", {31'd0, iram_req}, 32'd0);
        chk("rst_iram_addr", iram_addr, 32'd0);
        nrst = 1'b1;

        refill(32'h0000_1230, 0, -1, 0, 0);
        refill(32'h0000_1238, 0, -1, 0, 0);
        refill(32'h0000_123B, 0, -1, 0, 0);
        refill(32'h0000_4564, 0, 1, 3, 4);
        refill(32'h0000_5670, 1, -1, 0, 0);

        // Miss held through DONE: not accepted in cycle 9, req in cycle 11
        step();
        miss_cache  = 1'b1;
        ram_address = 32'h0000_6600;
        t0 = cyc;
        push_line(32'h0000_6600, t0, 4);
        step();
        serve_line(32'h0000_6600, 4, -1, 0, 0);
        chk("done_cycle9", cyc, t0 + 9);
        chk("req_cycle9", {31'd0, iram_req}, 32'd0);
        step();
        chk("req_cycle10", {31'd0, iram_req}, 32'd0);
        push_line(32'h0000_6600, cyc, 4);
        step();
        chk("req_cycle11", {31'd0, iram_req}, 32'd1);
        chk("req_cycle11_idx", cyc, t0 + 11);
        miss_cache = 1'b0;
        serve_line(32'h0000_6600, 4, -1, 0, 0);

        // Reset while waiting for word 1
        step();
        miss_cache  = 1'b1;
        ram_address = 32'h0000_7700;
        push_line(32'h0000_7700, cyc, 1);
        step();
        miss_cache = 1'b0;
        serve_line(32'h0000_7700, 1, -1, 0, 0);
        chk("w1_req", {31'd0, iram_req}, 32'd1);
        iram_ack = 1'b1;
        step();
        iram_ack = 1'b0;
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        chk("mid_rst_word_ready", {31'd0, word_ready}, 32'd0);
        chk("mid_rst_refill_done", {31'd0, refill_done}, 32'd0);
        chk("mid_rst_mem_word", mem_word, 32'd0);
        chk("mid_rst_word_offset", {30'd0, word_offset}, 32'd0);
        chk("mid_rst_iram_req", {31'd0, iram_req}, 32'd0);
        chk("mid_rst_iram_addr", iram_addr, 32'd0);
        iram_rvalid = 1'b1;
        iram_rdata  = 32'h1234_5678;
        step();
        iram_rvalid = 1'b0;
        step();
        chk("stray_rvalid_ready", {31'd0, word_ready}, 32'd0);
        chk("stray_rvalid_req", {31'd0, iram_req}, 32'd0);
        refill(32'h0000_2000, 0, -1, 0, 0);

        repeat (3) step();
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
